tdm_demux: RTL and testbench

//  Time-division demultiplexer: receive end of the N:1 slot-select link.

---
 rtl/tdm_demux.sv | 87 ++++++++
 tb/tb_tdm_demux.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// Receive side of an N:1 slot-select TDM link.
// Beats are collected into a shadow frame, and Y is published all at once when a frame completes.
module tdm_demux #(
  parameter int N = 16,
  parameter int W = 1,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    din,
  input  logic            din_valid,
  input  logic            frame_sync,
  output logic [N*W-1:0]  Y,
  output logic            frame_valid,
  output logic [SW-1:0]   sel,
  output logic            locked,
  output logic            sync_err
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic [N*W-1:0] shadow_q, shadow_d;
  logic [N*W-1:0] y_q, y_d;
  logic           frame_valid_q, frame_valid_d;
  logic           sync_err_q, sync_err_d;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    shadow_d      = shadow_q;
    y_d           = y_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          shadow_d[W-1:0] = din;
          sel_d           = SW'(1);
          state_d         = RUN;
        end
      end else if (frame_sync) begin
        // Sync anywhere but slot 0 drops the partial frame and restarts at lane 0.
        sync_err_d      = (sel_q != '0);
        shadow_d[W-1:0] = din;
        sel_d           = SW'(1);
      end else if (sel_q == '0) begin
        sync_err_d = 1'b1;
        state_d    = HUNT;
      end else if (sel_q == SW'(N-1)) begin
        // The last slot goes straight into Y so that every lane updates together.
        y_d           = {din, shadow_q[(N-1)*W-1:0]};
        frame_valid_d = 1'b1;
        sel_d         = '0;
      end else begin
        shadow_d[int'(sel_q)*W +: W] = din;
        sel_d                        = sel_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      sel_q         <= '0;
      shadow_q      <= '0;
      y_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      shadow_q      <= shadow_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign Y           = y_q;
  assign frame_valid = frame_valid_q;
  assign sel         = sel_q;
  assign locked      = (state_q == RUN);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized bench for tdm_demux with N=16,W=1 and N=5,W=4 instances.
// Each beat is checked against a queue-based frame model.
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        dinA = 1'b0, validA = 1'b0, syncA = 1'b0;
  logic [15:0] yA;
  logic        fvA, lockedA, errA;
  logic [3:0]  selA;

  logic [3:0]  dinB = 4'd0;
  logic        validB = 1'b0, syncB = 1'b0;
  logic [19:0] yB;
  logic        fvB, lockedB, errB;
  logic [2:0]  selB;

  int checks = 0;
  int errors = 0;

  int         dutSel = 0;
  int         mN = 16;
  int         mW = 1;
  bit         mLocked = 1'b0;
  logic [3:0] mCur[$];
  logic [63:0] mY = '0;
  bit         mFv = 1'b0;
  bit         mErr = 1'b0;

  tdm_demux #(.N(16), .W(1)) dutA (
    .clk(clk), .rst_n(rst_n), .din(dinA), .din_valid(validA), .frame_sync(syncA),
    .Y(yA), .frame_valid(fvA), .sel(selA), .locked(lockedA), .sync_err(errA)
  );

  tdm_demux #(.N(5), .W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .din(dinB), .din_valid(validB), .frame_sync(syncB),
    .Y(yB), .frame_valid(fvB), .sel(selB), .locked(lockedB), .sync_err(errB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s (dut %0d, t=%0t): got %0h expected %0h", tag, dutSel, $time, obs, exp);
    end
  endtask

  task automatic modelReset();
    mLocked = 1'b0;
    mCur.delete();
    mY   = '0;
    mFv  = 1'b0;
    mErr = 1'b0;
  endtask

  // Frame-level model: a frame is published once N slots have been collected after a sync.
  task automatic modelBeat(input logic [3:0] d, input bit fs);
    logic [3:0] v;
    v = d & 4'((1 << mW) - 1);
    if (!mLocked) begin
      if (fs) begin
        mLocked = 1'b1;
        mCur.delete();
        mCur.push_back(v);
      end
    end else if (fs) begin
      if (mCur.size() != 0) mErr = 1'b1;
      mCur.delete();
      mCur.push_back(v);
    end else if (mCur.size() == 0) begin
      mErr    = 1'b1;
      mLocked = 1'b0;
    end else begin
      mCur.push_back(v);
      if (mCur.size() == mN) begin
        mY = '0;
        for (int k = 0; k < mN; k++)
          for (int b = 0; b < mW; b++)
            mY[k*mW + b] = mCur[k][b];
        mFv = 1'b1;
        mCur.delete();
      end
    end
  endtask

  task automatic checkAll();
    if (dutSel == 0) begin
      checkOutput("Y", 64'(yA), mY);
      checkOutput("frame_valid", 64'(fvA), 64'(mFv));
      checkOutput("sel", 64'(selA), 64'(mCur.size()));
      checkOutput("locked", 64'(lockedA), 64'(mLocked));
      checkOutput("sync_err", 64'(errA), 64'(mErr));
    end else begin
      checkOutput("Y", 64'(yB), mY);
      checkOutput("frame_valid", 64'(fvB), 64'(mFv));
      checkOutput("sel", 64'(selB), 64'(mCur.size()));
      checkOutput("locked", 64'(lockedB), 64'(mLocked));
      checkOutput("sync_err", 64'(errB), 64'(mErr));
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, input bit fs, input bit v);
    if (dutSel == 0) begin
      dinA = d[0]; syncA = fs; validA = v;
    end else begin
      dinB = d; syncB = fs; validB = v;
    end
    @(posedge clk);
    #1;
    mFv  = 1'b0;
    mErr = 1'b0;
    if (v) modelBeat(d, fs);
    checkAll();
    validA = 1'b0;
    validB = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic sendFrame(input logic [63:0] data, input int gapMax);
    logic [3:0] s;
    for (int k = 0; k < mN; k++) begin
      if (gapMax > 0) begin
        int g;
        g = $urandom_range(0, gapMax);
        for (int i = 0; i < g; i++) applyStimulus(4'($urandom), 1'b0, 1'b0);
      end
      s = '0;
      for (int b = 0; b < mW; b++) s[b] = data[k*mW + b];
      applyStimulus(s, k == 0, 1'b1);
    end
  endtask

  task automatic randomRun(input int beats);
    bit fs;
    for (int i = 0; i < beats; i++) begin
      fs = ($urandom_range(0, 99) < ((mCur.size() == 0) ? 85 : 3));
      applyStimulus(4'($urandom), fs, $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    logic [63:0] pat;
    dutSel = 0; mN = 16; mW = 1;
    doReset();
    checkAll();

    $display("[TB] back-to-back A5C3 frames");
    for (int f = 0; f < 3; f++) begin
      sendFrame(64'hA5C3, 0);
      checkOutput("frameY", 64'(yA), 64'hA5C3);
    end

    $display("[TB] async reset mid-frame");
    for (int k = 0; k < 6; k++) applyStimulus(4'($urandom), k == 0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rstY", 64'(yA), 64'h0);
    checkOutput("rstSel", 64'(selA), 64'h0);
    checkOutput("rstLocked", 64'(lockedA), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();

    $display("[TB] hunt without sync");
    for (int i = 0; i < 5; i++) applyStimulus(4'($urandom), 1'b0, 1'b1);
    sendFrame(64'h0001, 0);
    checkOutput("huntY", 64'(yA), 64'h0001);

    $display("[TB] early sync at slot 7");
    sendFrame(64'h1234, 0);
    for (int k = 0; k < 7; k++) applyStimulus(4'($urandom), k == 0, 1'b1);
    pat = 64'h3C5B;
    applyStimulus(4'(pat[0]), 1'b1, 1'b1);
    checkOutput("earlyErr", 64'(errA), 64'h1);
    for (int k = 1; k < 16; k++) applyStimulus(4'(pat[k]), 1'b0, 1'b1);
    checkOutput("earlyY", 64'(yA), pat);

    $display("[TB] missing sync at slot 0");
    applyStimulus(4'd1, 1'b0, 1'b1);
    checkOutput("missLocked", 64'(lockedA), 64'h0);
    checkOutput("missY", 64'(yA), pat);
    sendFrame(64'hBEEF, 0);
    checkOutput("relockY", 64'(yA), 64'hBEEF);

    $display("[TB] frames with idle gaps");
    for (int f = 0; f < 3; f++) begin
      sendFrame(64'hA5C3, 3);
      checkOutput("gapY", 64'(yA), 64'hA5C3);
    end
    randomRun(400);

    $display("[TB] N=5 W=4 instance");
    dutSel = 1; mN = 5; mW = 4;
    doReset();
    checkAll();
    for (int f = 0; f < 3; f++) begin
      pat = 64'({$urandom, $urandom}) & 64'hFFFFF;
      sendFrame(pat, f);
      checkOutput("wrapY", 64'(yB), pat);
      checkOutput("wrapSel", 64'(selB), 64'h0);
    end
    randomRun(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
